bht_predictor: RTL

BHT_PREDICTOR -- requirements
Module: bht_predictor

---
 rtl/bht_pkg.sv | 17 +
 rtl/bht_predictor_if.sv | 27 ++
 rtl/bht_predictor_sat_counter2.sv | 21 ++
 rtl/bht_predictor.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: 2-bit counter encodings
// and the counter values used at reset and on allocation.
package bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST   = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    localparam int unsigned PC_W = 32;

endpackage : bht_pkg

// File: rtl/bht_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch predictor.
// The master drives the PCs and resolutions; the slave is the predictor.
interface bht_predictor_if;

    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        btb_hit;

    logic        ex_br;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        mispredict;

    modport master (
        output pc_if, ex_br, ex_pc, ex_taken, ex_target, ex_pred_taken,
        input  pred_taken, pred_target, btb_hit, mispredict
    );

    modport slave (
        input  pc_if, ex_br, ex_pc, ex_taken, ex_target, ex_pred_taken,
        output pred_taken, pred_target, btb_hit, mispredict
    );

endinterface : bht_predictor_if

// File: rtl/bht_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bht_pkg::*;
(
    input  ctr_e state_i,
    input  logic taken_i,
    output ctr_e state_o
);

    always_comb begin
        state_o = state_i;
        case (state_i)
            SNT:     state_o = taken_i ? WNT : SNT;
            WNT:     state_o = taken_i ? WT  : SNT;
            WT:      state_o = taken_i ? ST  : WNT;
            ST:      state_o = taken_i ? ST  : WT;
            default: state_o = state_i;
        endcase
    end

endmodule : sat_counter2

// File: rtl/bht_predictor.sv
// Direct-mapped branch history / target table with combinational lookup.
// Define BHT_STATS_EN to add the br_cnt / miss_cnt statistics outputs.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    bht_predictor_if.slave    bus
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]       br_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = PC_W - IDX_W - 2;
    localparam int unsigned TGT_W   = PC_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TGT_W-1:0]   target_q [ENTRIES];
    ctr_e               ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    ctr_e               rd_ctr;
    logic               rd_hit_c;

    logic [IDX_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic               wr_hit_c;
    ctr_e               ctr_step;

    logic               wr_en_d;
    logic [TAG_W-1:0]   wr_tag_d;
    logic [TGT_W-1:0]   wr_target_d;
    ctr_e               wr_ctr_d;

    logic               unused_lsbs;

    assign unused_lsbs = ^{bus.pc_if[1:0], bus.ex_pc[1:0], bus.ex_target[1:0]};

    // Fetch-side lookup: reads pre-update contents, same cycle as pc_if
    assign rd_idx   = bus.pc_if[IDX_W+1:2];
    assign rd_tag   = bus.pc_if[PC_W-1:IDX_W+2];
    assign rd_ctr   = ctr_q[rd_idx];
    assign rd_hit_c = !rst && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign bus.btb_hit     = rd_hit_c;
    assign bus.pred_taken  = rd_hit_c && ((rd_ctr == WT) || (rd_ctr == ST));
    assign bus.pred_target = rd_hit_c ? {target_q[rd_idx], 2'b00} : '0;

    assign bus.mispredict  = bus.ex_br & (bus.ex_pred_taken != bus.ex_taken);

    assign wr_idx   = bus.ex_pc[IDX_W+1:2];
    assign wr_tag   = bus.ex_pc[PC_W-1:IDX_W+2];
    assign wr_hit_c = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    sat_counter2 u_sat_counter2 (
        .state_i (ctr_q[wr_idx]),
        .taken_i (bus.ex_taken),
        .state_o (ctr_step)
    );

    // Resolution: train on a hit, allocate only on a taken miss
    always_comb begin
        wr_en_d     = 1'b0;
        wr_tag_d    = tag_q[wr_idx];
        wr_target_d = target_q[wr_idx];
        wr_ctr_d    = ctr_q[wr_idx];
        if (bus.ex_br) begin
            if (wr_hit_c) begin
                wr_en_d  = 1'b1;
                wr_ctr_d = ctr_step;
                if (bus.ex_taken) begin
                    wr_target_d = bus.ex_target[PC_W-1:2];
                end
            end else if (bus.ex_taken) begin
                wr_en_d     = 1'b1;
                wr_tag_d    = wr_tag;
                wr_target_d = bus.ex_target[PC_W-1:2];
                wr_ctr_d    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
        end else if (wr_en_d) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag_d;
            target_q[wr_idx] <= wr_target_d;
            ctr_q[wr_idx]    <= wr_ctr_d;
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] miss_cnt_d;

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.ex_br) begin
            br_cnt_d = br_cnt_q + 32'(1);
        end
        if (bus.mispredict) begin
            miss_cnt_d = miss_cnt_q + 32'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule : bht_predictor
